// File: rtl/pc_spill_unit.sv
// pc_spill_unit: memory-side executor of the two-beat call-cache ops (spill PC as two bytes, fill PC from two bytes).
// Optional bounds checking against CACHE_LO/CACHE_HI is compiled in when PC_SPILL_BOUNDS_EN is defined.
module pc_spill_unit #(
  parameter int                PC_W     = 16,
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] CACHE_LO = 16'h0000,
  parameter logic [ADDR_W-1:0] CACHE_HI = 16'h00FF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_spill_req,
  input  logic              i_fill_req,
  input  logic [PC_W-1:0]   i_pc_in,
  input  logic [ADDR_W-1:0] i_cache_ptr_in,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_fault,
  output logic [PC_W-1:0]   o_pc_out,
  output logic [ADDR_W-1:0] o_cache_ptr_out,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_we,
  output logic              o_mem_re,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic              i_mem_ready,
  output logic [2:0]        o_state
);

  // Memory handshake: a beat is presented by holding o_mem_we or o_mem_re high with
  // o_mem_addr/o_mem_wdata stable; it completes on the rising edge where i_mem_ready
  // is also high (read data is taken from i_mem_rdata on that same edge).
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WR_LO = 3'd1,
    S_WR_HI = 3'd2,
    S_RD_HI = 3'd3,
    S_RD_LO = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam int EW = ADDR_W + 1;

`ifdef PC_SPILL_BOUNDS_EN
  localparam logic CHECK_EN = 1'b1;
`else
  localparam logic CHECK_EN = 1'b0;
`endif

  state_t              r_state, w_state;
  logic                r_busy, w_busy;
  logic                r_done, w_done;
  logic                r_fault, w_fault;
  logic                r_we, w_we;
  logic                r_re, w_re;
  logic [ADDR_W-1:0]   r_addr, w_addr;
  logic [DATA_W-1:0]   r_wdata, w_wdata;
  logic [PC_W-1:0]     r_pc_out, w_pc_out;
  logic [ADDR_W-1:0]   r_ptr_out, w_ptr_out;
  logic [ADDR_W-1:0]   r_ptr, w_ptr;
  logic [PC_W-1:0]     r_pc, w_pc;
  logic [DATA_W-1:0]   r_hi, w_hi;

  logic [EW-1:0]       w_ptr_ext;
  logic                w_spill_in_range;
  logic                w_fill_in_range;
  logic                w_spill_ok;
  logic                w_fill_ok;

  // Range checks use one extra bit so ptr+1 and ptr-2 cannot wrap into range.
  assign w_ptr_ext        = {1'b0, i_cache_ptr_in};
  assign w_spill_in_range = (w_ptr_ext >= {1'b0, CACHE_LO}) &&
                            ((w_ptr_ext + EW'(1)) <= {1'b0, CACHE_HI});
  assign w_fill_in_range  = (w_ptr_ext >= ({1'b0, CACHE_LO} + EW'(2)));
  assign w_spill_ok       = !CHECK_EN || w_spill_in_range;
  assign w_fill_ok        = !CHECK_EN || w_fill_in_range;

  always_comb begin
    w_state   = r_state;
    w_busy    = r_busy;
    w_done    = 1'b0;
    w_fault   = 1'b0;
    w_we      = r_we;
    w_re      = r_re;
    w_addr    = r_addr;
    w_wdata   = r_wdata;
    w_pc_out  = r_pc_out;
    w_ptr_out = r_ptr_out;
    w_ptr     = r_ptr;
    w_pc      = r_pc;
    w_hi      = r_hi;
    case (r_state)
      S_IDLE: begin
        if (i_spill_req) begin
          w_ptr = i_cache_ptr_in;
          w_pc  = i_pc_in;
          if (w_spill_ok) begin
            w_state = S_WR_LO;
            w_busy  = 1'b1;
            w_we    = 1'b1;
            w_addr  = i_cache_ptr_in;
            w_wdata = i_pc_in[DATA_W-1:0];
          end else begin
            w_state = S_DONE;
            w_done  = 1'b1;
            w_fault = 1'b1;
          end
        end else if (i_fill_req) begin
          w_ptr = i_cache_ptr_in;
          if (w_fill_ok) begin
            w_state = S_RD_HI;
            w_busy  = 1'b1;
            w_re    = 1'b1;
            w_addr  = i_cache_ptr_in - ADDR_W'(1);
          end else begin
            w_state = S_DONE;
            w_done  = 1'b1;
            w_fault = 1'b1;
          end
        end
      end
      S_WR_LO: begin
        if (i_mem_ready) begin
          w_state = S_WR_HI;
          w_addr  = r_ptr + ADDR_W'(1);
          w_wdata = DATA_W'(r_pc[PC_W-1:DATA_W]);
        end
      end
      S_WR_HI: begin
        if (i_mem_ready) begin
          w_state   = S_DONE;
          w_we      = 1'b0;
          w_busy    = 1'b0;
          w_done    = 1'b1;
          w_ptr_out = r_ptr + ADDR_W'(2);
        end
      end
      S_RD_HI: begin
        if (i_mem_ready) begin
          w_state = S_RD_LO;
          w_hi    = i_mem_rdata;
          w_addr  = r_ptr - ADDR_W'(2);
        end
      end
      S_RD_LO: begin
        if (i_mem_ready) begin
          w_state   = S_DONE;
          w_re      = 1'b0;
          w_busy    = 1'b0;
          w_done    = 1'b1;
          w_pc_out  = PC_W'({r_hi, i_mem_rdata});
          w_ptr_out = r_ptr - ADDR_W'(2);
        end
      end
      S_DONE: begin
        w_state = S_IDLE;
      end
      default: begin
        w_state = S_IDLE;
        w_busy  = 1'b0;
        w_we    = 1'b0;
        w_re    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_fault   <= 1'b0;
      r_we      <= 1'b0;
      r_re      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_pc_out  <= '0;
      r_ptr_out <= '0;
      r_ptr     <= '0;
      r_pc      <= '0;
      r_hi      <= '0;
    end else begin
      r_state   <= w_state;
      r_busy    <= w_busy;
      r_done    <= w_done;
      r_fault   <= w_fault;
      r_we      <= w_we;
      r_re      <= w_re;
      r_addr    <= w_addr;
      r_wdata   <= w_wdata;
      r_pc_out  <= w_pc_out;
      r_ptr_out <= w_ptr_out;
      r_ptr     <= w_ptr;
      r_pc      <= w_pc;
      r_hi      <= w_hi;
    end
  end

  assign o_busy          = r_busy;
  assign o_done          = r_done;
  assign o_fault         = r_fault;
  assign o_pc_out        = r_pc_out;
  assign o_cache_ptr_out = r_ptr_out;
  assign o_mem_addr      = r_addr;
  assign o_mem_wdata     = r_wdata;
  assign o_mem_we        = r_we;
  assign o_mem_re        = r_re;
  assign o_state         = r_state;

endmodule

// File: tb/tb_pc_spill_unit.sv
// Testbench for pc_spill_unit: memory responder with programmable wait states, beat and completion scoreboards.
module tb_pc_spill_unit;

  logic        clk;
  logic        reset;
  logic        spill_req;
  logic        fill_req;
  logic [15:0] pc_in;
  logic [15:0] cache_ptr_in;
  logic        busy;
  logic        done;
  logic        fault;
  logic [15:0] pc_out;
  logic [15:0] cache_ptr_out;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [7:0]  mem_rdata;
  logic        mem_ready;
  logic [2:0]  state;

  pc_spill_unit dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_spill_req     (spill_req),
    .i_fill_req      (fill_req),
    .i_pc_in         (pc_in),
    .i_cache_ptr_in  (cache_ptr_in),
    .o_busy          (busy),
    .o_done          (done),
    .o_fault         (fault),
    .o_pc_out        (pc_out),
    .o_cache_ptr_out (cache_ptr_out),
    .o_mem_addr      (mem_addr),
    .o_mem_wdata     (mem_wdata),
    .o_mem_we        (mem_we),
    .o_mem_re        (mem_re),
    .i_mem_rdata     (mem_rdata),
    .i_mem_ready     (mem_ready),
    .o_state         (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // memory responder; ref_mem is the bench's own expectation of memory contents
  logic [7:0] mem     [0:65535];
  logic [7:0] ref_mem [0:65535];
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_we && mem_ready) mem[mem_addr] <= mem_wdata;
  end

  int n_checks = 0;
  int n_errors = 0;
  int wait_cfg = 0;
  int stall_cnt = 0;

  logic [25:0] exp_beat_q[$];  // {we, re, addr, wdata}
  logic [64:0] exp_done_q[$];  // {done cycle, fault, pc_out, cache_ptr_out}
  logic [15:0] model_pc  = 16'h0000;
  logic [15:0] model_ptr = 16'h0000;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic bit spill_ok(input logic [15:0] ptr);
`ifdef PC_SPILL_BOUNDS_EN
    int p;
    p = int'(ptr);
    return (p >= 0) && (p + 1 <= 255);
`else
    return (ptr == ptr);
`endif
  endfunction

  function automatic bit fill_ok(input logic [15:0] ptr);
`ifdef PC_SPILL_BOUNDS_EN
    int p;
    p = int'(ptr);
    return (p - 2 >= 0);
`else
    return (ptr == ptr);
`endif
  endfunction

  // ready generation, beat scoreboard and completion scoreboard
  always @(negedge clk) begin
    logic [64:0] e;
    if (mem_we || mem_re) begin
      if (stall_cnt < wait_cfg) begin
        mem_ready = 1'b0;
        stall_cnt++;
      end else begin
        mem_ready = 1'b1;
        stall_cnt = 0;
      end
      if (exp_beat_q.size() == 0) begin
        check("unexpected_beat", 64'd1, 64'd0);
      end else begin
        check("beat", {38'd0, mem_we, mem_re, mem_addr, (mem_we ? mem_wdata : 8'h00)},
              {38'd0, exp_beat_q[0]});
        if (mem_ready) void'(exp_beat_q.pop_front());
      end
    end else begin
      mem_ready = 1'b1;
      stall_cnt = 0;
    end
    if (done) begin
      if (exp_done_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = exp_done_q.pop_front();
        check("done_cycle", 64'(cyc), 64'(e[64:33]));
        check("fault", 64'(fault), 64'(e[32]));
        check("pc_out", 64'(pc_out), 64'(e[31:16]));
        check("cache_ptr_out", 64'(cache_ptr_out), 64'(e[15:0]));
        check("busy_at_done", 64'(busy), 64'd0);
      end
    end else if (fault) begin
      check("fault_without_done", 64'd1, 64'd0);
    end
  end

  // driver: called at a negedge with the DUT idle; pushes expectations then drops requests
  task automatic drive_op(input bit spill, input bit fill, input logic [15:0] pc,
                          input logic [15:0] ptr, input bit exp_done);
    int c;
    int lat;
    bit ok;
    c = cyc;
    spill_req    = spill;
    fill_req     = fill;
    pc_in        = pc;
    cache_ptr_in = ptr;
    if (spill) begin
      ok = spill_ok(ptr);
      if (ok) begin
        exp_beat_q.push_back({1'b1, 1'b0, ptr, pc[7:0]});
        exp_beat_q.push_back({1'b1, 1'b0, ptr + 16'd1, pc[15:8]});
        ref_mem[ptr]         = pc[7:0];
        ref_mem[ptr + 16'd1] = pc[15:8];
        model_ptr = ptr + 16'd2;
        lat = 3 + 2 * wait_cfg;
      end else begin
        lat = 1;
      end
    end else begin
      ok = fill_ok(ptr);
      if (ok) begin
        exp_beat_q.push_back({1'b0, 1'b1, ptr - 16'd1, 8'h00});
        exp_beat_q.push_back({1'b0, 1'b1, ptr - 16'd2, 8'h00});
        model_pc  = {ref_mem[ptr - 16'd1], ref_mem[ptr - 16'd2]};
        model_ptr = ptr - 16'd2;
        lat = 3 + 2 * wait_cfg;
      end else begin
        lat = 1;
      end
    end
    if (exp_done) exp_done_q.push_back({32'(c + lat), !ok, model_pc, model_ptr});
    @(negedge clk);
    spill_req = 1'b0;
    fill_req  = 1'b0;
    if (ok) check("busy_after_accept", 64'(busy), 64'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_done_q.size() != 0 || exp_beat_q.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      check("timeout", 64'd1, 64'd0);
      exp_done_q.delete();
      exp_beat_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] v;
    for (int i = 0; i < 65536; i++) begin
      v = 8'($urandom_range(0, 255));
      mem[i]     = v;
      ref_mem[i] = v;
    end
    reset = 1'b1;
    spill_req = 1'b0;
    fill_req = 1'b0;
    pc_in = 16'h0000;
    cache_ptr_in = 16'h0000;
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_fault", 64'(fault), 64'd0);
    check("rst_we", 64'(mem_we), 64'd0);
    check("rst_re", 64'(mem_re), 64'd0);
    check("rst_pc_out", 64'(pc_out), 64'd0);
    check("rst_ptr_out", 64'(cache_ptr_out), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_wdata", 64'(mem_wdata), 64'd0);
    check("rst_state", 64'(state), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // basic spill and fill back
    drive_op(1'b1, 1'b0, 16'hBEEF, 16'h0010, 1'b1);
    wait_idle();
    check("mem_0010", 64'(mem[16'h0010]), 64'hEF);
    check("mem_0011", 64'(mem[16'h0011]), 64'hBE);
    drive_op(1'b0, 1'b1, 16'h0000, 16'h0012, 1'b1);
    wait_idle();
    check("fill_pc_beef", 64'(pc_out), 64'hBEEF);

    // wait states on every beat
    wait_cfg = 3;
    drive_op(1'b1, 1'b0, 16'h5A3C, 16'h0040, 1'b1);
    wait_idle();
    wait_cfg = 2;
    drive_op(1'b0, 1'b1, 16'h0000, 16'h0042, 1'b1);
    wait_idle();
    wait_cfg = 0;

    // simultaneous requests: spill wins; a fill while busy is ignored
    drive_op(1'b1, 1'b1, 16'h1234, 16'h0020, 1'b1);
    fill_req     = 1'b1;
    cache_ptr_in = 16'h0022;
    @(negedge clk);
    fill_req = 1'b0;
    wait_idle();

    // reset during WR_HI
    drive_op(1'b1, 1'b0, 16'h7788, 16'h0050, 1'b0);
    @(negedge clk);
    check("in_wr_hi", 64'(state), 64'd2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_pc  = 16'h0000;
    model_ptr = 16'h0000;
    check("midrst_we", 64'(mem_we), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_state", 64'(state), 64'd0);
    repeat (3) @(negedge clk);
    drive_op(1'b1, 1'b0, 16'hCAFE, 16'h0030, 1'b1);
    wait_idle();

    // pointer wrap / low-bound cases
    drive_op(1'b1, 1'b0, 16'hA55A, 16'hFFFF, 1'b1);
    wait_idle();
    drive_op(1'b0, 1'b1, 16'h0000, 16'h0001, 1'b1);
    wait_idle();

    // random mix
    for (int k = 0; k < 24; k++) begin
      wait_cfg = $urandom_range(0, 2);
      if ($urandom_range(0, 1) == 1)
        drive_op(1'b1, 1'b0, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 16'h0104)), 1'b1);
      else
        drive_op(1'b0, 1'b1, 16'h0000, 16'($urandom_range(0, 16'h0104)), 1'b1);
      wait_idle();
    end
    wait_cfg = 0;

    check("beat_q_empty", 64'(exp_beat_q.size()), 64'd0);
    check("done_q_empty", 64'(exp_done_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
